// File: rtl/etai_pkg.sv
// Shared types and width helpers for the ETAI accuracy monitors.
package etai_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } etai_mon_state_t;

    function automatic int ED_W(input int n);
        return n + 1;
    endfunction

    function automatic int CNT_W(input int win);
        return $clog2(win + 1);
    endfunction

    // Sized so WIN samples of the largest ED can never overflow.
    function automatic int SUM_W(input int n, input int win);
        return ED_W(n) + CNT_W(win);
    endfunction

endpackage

// File: rtl/etai_err_dist.sv
// Error distance |a - b| on unsigned operands; shared by the approximate-adder monitors.
module etai_err_dist #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d
);

    assign d = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/etai_err_monitor.sv
// Windowed error statistics (count, ED sum, max ED) for the ETAI approximate adder.
module etai_err_monitor
    import etai_pkg::*;
#(
    parameter int N   = 16,
    parameter int K   = 8,
    parameter int WIN = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            X,
    input  logic [N-1:0]            Y,
    input  logic [N-1:0]            S,
    input  logic                    Cout,
    output logic                    rpt_valid,
    input  logic                    rpt_ready,
    output logic [CNT_W(WIN)-1:0]   err_cnt,
    output logic [SUM_W(N,WIN)-1:0] ed_sum,
    output logic [ED_W(N)-1:0]      ed_max,
    output logic                    busy
);

    localparam int EW = ED_W(N);
    localparam int CW = CNT_W(WIN);
    localparam int SW = SUM_W(N, WIN);

    etai_mon_state_t state;
    logic [CW-1:0]   smp_cnt;
    logic            drain_cnt;
    logic            vld_s1;
    logic [EW-1:0]   exact_q;
    logic [EW-1:0]   approx_q;
    logic [EW-1:0]   ed;
    logic            accept;
    logic            last_beat;

    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (smp_cnt == CW'(WIN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            rpt_valid <= 1'b0;
            busy      <= 1'b0;
            smp_cnt   <= '0;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        smp_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) smp_cnt <= smp_cnt + CW'(1);
                    if (last_beat) begin
                        state     <= ST_DRAIN;
                        in_ready  <= 1'b0;
                        drain_cnt <= 1'b0;
                    end
                end
                // Two cycles lets the last beat clear both pipeline stages.
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        state     <= ST_REPORT;
                        rpt_valid <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (rpt_ready) begin
                        state     <= ST_IDLE;
                        rpt_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    rpt_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    etai_err_dist #(.W(EW)) u_err_dist (
        .a (exact_q),
        .b (approx_q),
        .d (ed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_s1   <= 1'b0;
            exact_q  <= '0;
            approx_q <= '0;
            err_cnt  <= '0;
            ed_sum   <= '0;
            ed_max   <= '0;
        end else begin
            vld_s1   <= accept;
            exact_q  <= {1'b0, X} + {1'b0, Y};
            approx_q <= {Cout, S};
            if (state == ST_IDLE && start) begin
                err_cnt <= '0;
                ed_sum  <= '0;
                ed_max  <= '0;
            end else if (vld_s1) begin
                ed_sum <= ed_sum + SW'(ed);
                if (ed != '0)    err_cnt <= err_cnt + CW'(1);
                if (ed > ed_max) ed_max  <= ed;
            end
        end
    end

endmodule

// File: doc/etai_err_monitor.md
# etai_err_monitor

Windowed error-statistics collector placed directly downstream of the ETAI approximate adder. Each beat accepts the operands and the ETAI result, recomputes the exact sum, and accumulates the error distance (ED) over a window of WIN samples. The block then presents one report: error count, ED sum and maximum ED. It is used in characterisation runs to quantify ETAI accuracy for a given N/K split without software post-processing.

## Interface
- N, 16, operand/sum width (matches ETAI N)
- K, 8, ETAI approximate-part width; informational only, no effect on logic
- WIN, 256, samples per report window, ≥1

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  opens a new window; honoured only in IDLE
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- X, Y  in  N  operands fed to ETAI
- S  in  N  ETAI sum
- Cout  in  1  ETAI carry-out
- rpt_valid  out  1  report available
- rpt_ready  in  1  report consumed when rpt_valid && rpt_ready
- err_cnt  out  $clog2(WIN+1)  samples with ED≠0
- ed_sum  out  N+1+$clog2(WIN+1)  sum of ED over the window
- ed_max  out  N+1  largest ED in the window
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, RUN, DRAIN, REPORT.
- IDLE: in_ready=0. start=1 → clear err_cnt, ed_sum, ed_max and the sample counter; go to RUN.
- RUN: in_ready=1 (registered state decode, not dependent on in_valid). Each accepted beat increments the sample counter. When the accepted beat is number WIN, go to DRAIN.
- DRAIN: in_ready=0. Fixed 2 cycles, then REPORT.
- REPORT: rpt_valid=1. All report outputs are stable until rpt_ready=1, then go to IDLE. Report outputs keep their values in IDLE until the next start.
- start outside IDLE is ignored.
- Pipeline, 2 stages:
  - Stage 1 registers exact = {1'b0,X}+{1'b0,Y} (N+1 bits), approx = {Cout,S} and a valid bit.
  - Stage 2 computes ED = |exact − approx| as N+1-bit unsigned, covering both signs of error. If valid, it adds ED to ed_sum, increments err_cnt when ED≠0, and updates ed_max when ED > ed_max.
- Width rules:
  - No accumulator can overflow; widths are sized for WIN·(2^(N+1)−1).
  - ED comparison is unsigned. On equal maxima, ed_max is unchanged.

## Timing
- Reset values: in_ready=0, rpt_valid=0, busy=0, err_cnt=0, ed_sum=0, ed_max=0, state=IDLE, pipeline valids=0.
- start sampled in cycle t → in_ready=1 from cycle t+1.
- Beat accepted in cycle t contributes to the accumulators at the edge ending cycle t+1.
- WIN-th beat accepted in cycle t: in_ready=0 in cycle t+1, rpt_valid=1 from cycle t+3.
- Input gaps (in_valid=0) stall counting only; there is no timeout.
- rpt_ready already high on the first REPORT cycle: single-cycle report, IDLE the next cycle.
- rst in any state, including mid-window, DRAIN or REPORT: next cycle equals the reset values. Partial statistics are discarded.
- rst and start in the same cycle: rst wins.

## Structure
- Package etai_pkg:
  - state enum etai_mon_state_t
  - width helpers ED_W(N)=N+1, CNT_W(WIN)=$clog2(WIN+1), SUM_W(N,WIN)=ED_W+CNT_W
- Sub-module etai_err_dist: combinational |a−b| on ED_W-bit unsigned operands. It is reused later by the other approximate-adder monitors.
- Top module: FSM, sample counter, pipeline registers, accumulators.

## Test plan
- Reset: assert rst 3 cycles with random inputs → all outputs 0, in_ready=0, busy=0.
- WIN=4, exact results (X=16'h1234, Y=16'h0101, S=16'h1335, Cout=0) ×4 → err_cnt=0, ed_sum=0, ed_max=0.
  - rpt_valid rises exactly 3 cycles after the 4th accept.
- WIN=4, mixed beats → err_cnt=2, ed_sum=256, ed_max=255:
  - X=Y=16'h00FF, S=16'h00FF, Cout=0 → ED 255
  - X=Y=16'hFFFF, S=16'hFFFF, Cout=1 → ED 1
  - two exact beats
- WIN=2, sign and width check → ed_max=17'h10000, ed_sum=65539:
  - X=Y=16'h8000, S=0, Cout=0 → ED 65536
  - X=Y=0, S=16'h0003, Cout=0 → approx>exact, ED 3
- Backpressure, WIN=4:
  - in_valid gaps between beats → counts still cover exactly 4 beats.
  - rpt_ready low 10 cycles → outputs stable, in_ready=0, a start pulse is ignored.
  - rpt_ready=1 → IDLE next cycle.
- Mid-window reset: rst after 2 of 4 beats → zeros next cycle. A fresh start plus 4 exact beats → report all zero.
